dtb_tracer: RTL and testbench
=============================

Name: dtb_tracer

Overview:
- Bridge between FPGA-side trace/stream pins and the trace-buffer memory port of the debug trace buffer.
- Capture path: deserializes 2**NTRACE_I trace bits per cycle into TRB_WIDTH-bit memory words and tracks the trigger position.
- Readout path: fetches memory words via a load handshake and serializes them to FPGA_STREAM_O.
- Trace mode (MODE_I=0): free-running readout. Stream mode (MODE_I=1): readout is consumer-paced by FPGA_READ_I.

Parameters:
TRB_WIDTH, 32, memory word width; power of two
TRB_MAX_TRACES, 8, maximum trace/stream lanes; power of two
TRB_NTRACE_BITS, 2, width of NTRACE_I; legal values 0..log2(TRB_MAX_TRACES)

Ports:
FPGA_CLK_I  in  1  single clock
RST_I  in  1  synchronous, active-low reset
MODE_I  in  1  0 = trace mode, 1 = stream mode
NTRACE_I  in  TRB_NTRACE_BITS  active lanes = 2**NTRACE_I
EVENT_POS_O  out  clog2(TRB_WIDTH)  word bit index of first trigger beat
TRG_EVENT_O  out  1  sticky trigger-seen flag
TRG_DELAYED_I  in  1  delayed trigger event from controller
DATA_I  in  TRB_WIDTH  word from memory
LOAD_REQUEST_O  out  1  load buffer empty, requests a word
LOAD_GRANT_I  in  1  DATA_I valid; load it
DATA_O  out  TRB_WIDTH  completed capture word
STORE_O  out  1  DATA_O valid for storing
STORE_PERM_I  in  1  memory accepts a store
FPGA_TRIG_I  in  1  trigger input
FPGA_TRACE_I  in  TRB_MAX_TRACES  trace lanes
FPGA_WRITE_VALID_O  out  1  capture accepting beats
FPGA_READ_I  in  1  stream-mode consume strobe
FPGA_STREAM_O  out  TRB_MAX_TRACES  serialized lanes
FPGA_TRIG_O  out  1  trace mode: delayed trigger; stream mode: stream valid

Behaviour:
- Reset values: all registers cleared. TRG_EVENT_O=0, EVENT_POS_O=0, STORE_O=0, DATA_O=0, FPGA_STREAM_O=0, FPGA_TRIG_O=0, FPGA_WRITE_VALID_O=0.
- LOAD_REQUEST_O is combinational: NOT(load buffer valid). It therefore reads 1 during and directly after reset.
- Beats: N=2**NTRACE_I, beats per word B=TRB_WIDTH/N. The beat counter idles for the first rising edge after reset release. From the 2nd edge it cycles 0..B-1 continuously. At beat k, word bits [k*N +: N] are in play. The edge at beat B-1 is the word boundary.
- Capture (both modes): each beat samples FPGA_TRACE_I[N-1:0] into bits [k*N +: N] of the shift word.
  - At the boundary the completed word is copied to a pending register.
  - STORE_O is high while the word is pending and STORE_PERM_I=1. With permission already high, STORE_O is visible right after the boundary edge.
  - Without permission the word is held with STORE_O=0. STORE_O rises at the first edge after STORE_PERM_I goes 1. The pending word clears one cycle after STORE_O.
  - STORE_O stays 0 at every non-boundary beat.
- Overrun: if a new word completes while one is still pending, FPGA_WRITE_VALID_O drops and the capture counter stalls until pending clears. FPGA_WRITE_VALID_O is 1 otherwise, after the idle edge.
- Trigger: on the first beat with FPGA_TRIG_I=1, at that edge, TRG_EVENT_O:=1 and EVENT_POS_O:=k*N. Both stay sticky until reset. Later FPGA_TRIG_I values are ignored.
- Load buffer: the edge with LOAD_GRANT_I=1 while the buffer is empty captures DATA_I and marks the buffer valid. A grant while the buffer is full is ignored.
- Trace mode readout:
  - At each word boundary the stream register loads from the load buffer (zeros if empty), and the buffer clears so LOAD_REQUEST_O rises.
  - FPGA_STREAM_O = stream register bits [k*N +: N] for the current beat; lanes >= N are 0.
  - FPGA_TRIG_O = TRG_DELAYED_I registered by one edge.
- Stream mode readout:
  - When the stream register is invalid and the buffer is valid, or a grant arrives, the word moves to the stream register on that edge. Valid:=1, read pointer:=0, buffer freed.
  - FPGA_STREAM_O = bits [ptr*N +: N] and is independent of the beat counter.
  - Each edge with FPGA_READ_I=1 and valid advances ptr. At the last ptr, valid clears on that edge, or reloads if the buffer holds a word.
  - FPGA_TRIG_O = valid. FPGA_READ_I while invalid is ignored.
- MODE_I and NTRACE_I are static between resets; changing them outside reset is undefined.
- Reset mid-operation discards all words, flags and pointers.

Decomposition:
- DTB_PKG: TRB_WIDTH, TRB_MAX_TRACES, TRB_NTRACE_BITS, and a mode enum (TRACE, STREAM).
- One sub-module, dtb_serializer: stream register, pointer and valid logic for both modes. Capture, trigger and load-buffer logic stay in the top.

Test Plan:
- Capture: NTRACE=0/1/2, STORE_PERM=1, random 32-bit word over B beats -> STORE_O=0 until the boundary edge, then STORE_O=1 and DATA_O==word.
- Capture with STORE_PERM=0 -> STORE_O=0 after the boundary; raise perm -> one edge later STORE_O=1, DATA_O==word.
- Trigger at random position p (NTRACE=1) -> TRG_EVENT_O=0 before beat floor(p/2), 1 from that beat on; EVENT_POS_O==2*floor(p/2).
- Trace mode readout: grant word W on the 2nd edge after reset -> LOAD_REQUEST_O re-rises after edge B+1; the next B beats of FPGA_STREAM_O reassemble W.
- TRG_DELAYED_I 0->1 in trace mode -> FPGA_TRIG_O=1 after one edge.
- Stream mode: grant W -> FPGA_TRIG_O=1 and LOAD_REQUEST_O=1 next cycle; random FPGA_READ_I steps through W exactly; after the last read with no second grant -> FPGA_TRIG_O=0.

Source files
------------

// File: rtl/dtb_pkg.sv
// rtl/dtb_pkg.sv - shared constants, mode enum and lane-mask helper for the debug trace bridge
package dtb_pkg;

    localparam int TRB_WIDTH       = 32;
    localparam int TRB_MAX_TRACES  = 8;
    localparam int TRB_NTRACE_BITS = 2;
    localparam int TRB_POS_BITS    = $clog2(TRB_WIDTH);

    typedef enum logic {
        TRACE  = 1'b0,
        STREAM = 1'b1
    } dtb_mode_e;

    // Low 2**ntrace bits set; selects the active lanes within a word slice.
    function automatic logic [TRB_WIDTH-1:0] lane_mask(input logic [TRB_NTRACE_BITS-1:0] ntrace);
        logic [TRB_WIDTH-1:0] m;
        m = '0;
        for (int i = 0; i < TRB_MAX_TRACES; i++) begin
            if (i < (1 << ntrace)) begin
                m[i] = 1'b1;
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/dtb_serializer.sv
// rtl/dtb_serializer.sv - readout stream register, pointer and valid logic for trace and stream modes
module dtb_serializer
    import dtb_pkg::*;
(
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       mode,
    input  logic [TRB_NTRACE_BITS-1:0] ntrace,
    input  logic [TRB_POS_BITS-1:0]    beat_pos,
    input  logic [TRB_POS_BITS-1:0]    last_index,
    input  logic                       word_tick,
    input  logic                       buf_valid,
    input  logic [TRB_WIDTH-1:0]       buf_data,
    input  logic                       grant,
    input  logic [TRB_WIDTH-1:0]       grant_data,
    input  logic                       read,
    input  logic                       trg_delayed,
    output logic                       buf_take,
    output logic                       bypass,
    output logic [TRB_MAX_TRACES-1:0]  stream,
    output logic                       trig
);

    logic [TRB_WIDTH-1:0]    stream_reg;
    logic [TRB_POS_BITS-1:0] ptr;
    logic [TRB_POS_BITS-1:0] sel_pos;
    logic                    valid;
    logic                    trg_d;
    logic                    is_stream;
    logic                    can_load;

    assign is_stream = (mode == STREAM);
    assign can_load  = !valid || (read && ptr == last_index);

    // A grant arriving while the stream register can accept goes straight past the load buffer.
    always_comb begin
        buf_take = 1'b0;
        bypass   = 1'b0;
        if (is_stream) begin
            if (can_load && buf_valid) begin
                buf_take = 1'b1;
            end else if (can_load && grant) begin
                bypass = 1'b1;
            end
        end else begin
            buf_take = word_tick && buf_valid;
        end
    end

    assign sel_pos = is_stream ? (ptr << ntrace) : beat_pos;
    assign stream  = TRB_MAX_TRACES'((stream_reg >> sel_pos) & lane_mask(ntrace));
    assign trig    = is_stream ? valid : trg_d;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            stream_reg <= '0;
            ptr        <= '0;
            valid      <= 1'b0;
            trg_d      <= 1'b0;
        end else begin
            trg_d <= trg_delayed;
            if (is_stream) begin
                if (buf_take) begin
                    stream_reg <= buf_data;
                    valid      <= 1'b1;
                    ptr        <= '0;
                end else if (bypass) begin
                    stream_reg <= grant_data;
                    valid      <= 1'b1;
                    ptr        <= '0;
                end else if (read && valid) begin
                    if (ptr == last_index) begin
                        valid <= 1'b0;
                    end else begin
                        ptr <= ptr + 1'b1;
                    end
                end
            end else if (word_tick) begin
                stream_reg <= buf_valid ? buf_data : '0;
            end
        end
    end

endmodule

// File: rtl/dtb_tracer.sv
// rtl/dtb_tracer.sv - trace capture deserializer, trigger tracking and load buffer for the debug trace buffer
module dtb_tracer
    import dtb_pkg::*;
(
    input  logic                       FPGA_CLK_I,
    input  logic                       RST_I,
    input  logic                       MODE_I,
    input  logic [TRB_NTRACE_BITS-1:0] NTRACE_I,
    output logic [TRB_POS_BITS-1:0]    EVENT_POS_O,
    output logic                       TRG_EVENT_O,
    input  logic                       TRG_DELAYED_I,
    input  logic [TRB_WIDTH-1:0]       DATA_I,
    output logic                       LOAD_REQUEST_O,
    input  logic                       LOAD_GRANT_I,
    output logic [TRB_WIDTH-1:0]       DATA_O,
    output logic                       STORE_O,
    input  logic                       STORE_PERM_I,
    input  logic                       FPGA_TRIG_I,
    input  logic [TRB_MAX_TRACES-1:0]  FPGA_TRACE_I,
    output logic                       FPGA_WRITE_VALID_O,
    input  logic                       FPGA_READ_I,
    output logic [TRB_MAX_TRACES-1:0]  FPGA_STREAM_O,
    output logic                       FPGA_TRIG_O
);

    logic [TRB_POS_BITS-1:0] beat;
    logic [TRB_POS_BITS-1:0] beat_last;
    logic [TRB_POS_BITS-1:0] beat_pos;
    logic [TRB_WIDTH-1:0]    lane_m;
    logic [TRB_WIDTH-1:0]    shift_word;
    logic [TRB_WIDTH-1:0]    word_next;
    logic [TRB_WIDTH-1:0]    buf_data;
    logic                    started;
    logic                    write_valid;
    logic                    pending;
    logic                    pending_n;
    logic                    load_pending;
    logic                    store_q;
    logic                    slot_free;
    logic                    beat_active;
    logic                    at_boundary;
    logic                    buf_valid;
    logic                    buf_take;
    logic                    bypass;

    assign lane_m      = lane_mask(NTRACE_I);
    assign beat_last   = TRB_POS_BITS'((TRB_WIDTH >> NTRACE_I) - 1);
    assign beat_pos    = beat << NTRACE_I;
    assign beat_active = started && write_valid;
    assign at_boundary = (beat == beat_last);
    assign slot_free   = !pending || store_q;
    assign word_next   = (shift_word & ~(lane_m << beat_pos))
                       | ((TRB_WIDTH'(FPGA_TRACE_I) & lane_m) << beat_pos);

    // A stalled word (write_valid low) is already complete in shift_word and moves once the slot frees.
    assign load_pending = slot_free && ((beat_active && at_boundary) || (started && !write_valid));
    assign pending_n    = load_pending || (pending && !store_q);

    assign STORE_O            = store_q;
    assign FPGA_WRITE_VALID_O = write_valid;
    assign LOAD_REQUEST_O     = !buf_valid;

    always_ff @(posedge FPGA_CLK_I) begin
        if (!RST_I) begin
            beat        <= '0;
            started     <= 1'b0;
            write_valid <= 1'b0;
            shift_word  <= '0;
            DATA_O      <= '0;
            pending     <= 1'b0;
            store_q     <= 1'b0;
            TRG_EVENT_O <= 1'b0;
            EVENT_POS_O <= '0;
        end else begin
            started <= 1'b1;
            pending <= pending_n;
            store_q <= pending_n && STORE_PERM_I;
            if (!started) begin
                write_valid <= 1'b1;
            end
            if (beat_active) begin
                shift_word <= word_next;
                if (FPGA_TRIG_I && !TRG_EVENT_O) begin
                    TRG_EVENT_O <= 1'b1;
                    EVENT_POS_O <= beat_pos;
                end
                if (at_boundary) begin
                    if (slot_free) begin
                        DATA_O <= word_next;
                        beat   <= '0;
                    end else begin
                        write_valid <= 1'b0;
                    end
                end else begin
                    beat <= beat + 1'b1;
                end
            end else if (started && !write_valid && slot_free) begin
                DATA_O      <= shift_word;
                write_valid <= 1'b1;
                beat        <= '0;
            end
        end
    end

    always_ff @(posedge FPGA_CLK_I) begin
        if (!RST_I) begin
            buf_valid <= 1'b0;
            buf_data  <= '0;
        end else if (buf_take) begin
            buf_valid <= 1'b0;
        end else if (LOAD_GRANT_I && !buf_valid && !bypass) begin
            buf_valid <= 1'b1;
            buf_data  <= DATA_I;
        end
    end

    dtb_serializer u_serializer (
        .clk         (FPGA_CLK_I),
        .resetn      (RST_I),
        .mode        (MODE_I),
        .ntrace      (NTRACE_I),
        .beat_pos    (beat_pos),
        .last_index  (beat_last),
        .word_tick   (beat_active && at_boundary),
        .buf_valid   (buf_valid),
        .buf_data    (buf_data),
        .grant       (LOAD_GRANT_I),
        .grant_data  (DATA_I),
        .read        (FPGA_READ_I),
        .trg_delayed (TRG_DELAYED_I),
        .buf_take    (buf_take),
        .bypass      (bypass),
        .stream      (FPGA_STREAM_O),
        .trig        (FPGA_TRIG_O)
    );

endmodule

// File: tb/tb_dtb_tracer.sv
// tb/tb_dtb_tracer.sv - scoreboard bench for dtb_tracer capture, trigger and readout paths
module tb_dtb_tracer;
    import dtb_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mode_i;
    logic [1:0]  ntrace;
    logic [4:0]  event_pos;
    logic        trg_event;
    logic        trg_delayed;
    logic [31:0] data_in;
    logic        load_req;
    logic        load_grant;
    logic [31:0] data_out;
    logic        store;
    logic        store_perm;
    logic        trig_in;
    logic [7:0]  trace;
    logic        write_valid;
    logic        read_i;
    logic [7:0]  stream;
    logic        trig_out;

    logic [31:0] exp_q[$];
    int          n_checks = 0;
    int          n_pass   = 0;

    always #5 clk = ~clk;

    dtb_tracer dut (
        .FPGA_CLK_I         (clk),
        .RST_I              (rst_n),
        .MODE_I             (mode_i),
        .NTRACE_I           (ntrace),
        .EVENT_POS_O        (event_pos),
        .TRG_EVENT_O        (trg_event),
        .TRG_DELAYED_I      (trg_delayed),
        .DATA_I             (data_in),
        .LOAD_REQUEST_O     (load_req),
        .LOAD_GRANT_I       (load_grant),
        .DATA_O             (data_out),
        .STORE_O            (store),
        .STORE_PERM_I       (store_perm),
        .FPGA_TRIG_I        (trig_in),
        .FPGA_TRACE_I       (trace),
        .FPGA_WRITE_VALID_O (write_valid),
        .FPGA_READ_I        (read_i),
        .FPGA_STREAM_O      (stream),
        .FPGA_TRIG_O        (trig_out)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic reset_dut(input logic mode, input int nt);
        @(negedge clk);
        rst_n       = 1'b0;
        mode_i      = mode;
        ntrace      = 2'(nt);
        trg_delayed = 1'b0;
        data_in     = '0;
        load_grant  = 1'b0;
        store_perm  = 1'b0;
        trig_in     = 1'b0;
        trace       = '0;
        read_i      = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic drive_word(input int nt, input logic [31:0] w);
        int          n;
        int          b;
        logic [31:0] sh;
        logic [7:0]  m8;
        n  = 1 << nt;
        b  = 32 / n;
        m8 = 8'((1 << n) - 1);
        for (int k = 0; k < b; k++) begin
            sh    = w >> (k * n);
            trace = (8'($urandom()) & ~m8) | (sh[7:0] & m8);
            @(negedge clk);
            if (k < b - 1) check("store_early", 32'(store), 32'd0);
        end
    endtask

    initial begin
        logic [31:0] w;
        logic [31:0] got;
        logic [7:0]  hi;
        int          p;
        int          t;
        int          reads;
        int          iter;
        logic        r;

        rst_n = 1'b0;
        reset_dut(TRACE, 0);
        check("rst_trg_event", 32'(trg_event), 32'd0);
        check("rst_event_pos", 32'(event_pos), 32'd0);
        check("rst_store", 32'(store), 32'd0);
        check("rst_data_o", data_out, 32'd0);
        check("rst_stream", 32'(stream), 32'd0);
        check("rst_trig_o", 32'(trig_out), 32'd0);
        check("rst_write_valid", 32'(write_valid), 32'd0);
        check("rst_load_req", 32'(load_req), 32'd1);

        // Capture with permission held high, all lane widths
        for (int nt = 0; nt < 3; nt++) begin
            reset_dut(TRACE, nt);
            store_perm = 1'b1;
            @(negedge clk);
            check("write_valid", 32'(write_valid), 32'd1);
            w = $urandom();
            exp_q.push_back(w);
            drive_word(nt, w);
            check("store_boundary", 32'(store), 32'd1);
            check("data_o", data_out, exp_q.pop_front());
            @(negedge clk);
            check("store_clear", 32'(store), 32'd0);
        end

        // Capture held without permission
        reset_dut(TRACE, 1);
        @(negedge clk);
        w = $urandom();
        exp_q.push_back(w);
        drive_word(1, w);
        check("store_noperm", 32'(store), 32'd0);
        repeat (3) @(negedge clk);
        check("store_noperm_hold", 32'(store), 32'd0);
        store_perm = 1'b1;
        @(negedge clk);
        check("store_perm_rise", 32'(store), 32'd1);
        check("data_o_held", data_out, exp_q.pop_front());
        @(negedge clk);
        check("store_perm_clear", 32'(store), 32'd0);

        // Trigger position
        reset_dut(TRACE, 1);
        @(negedge clk);
        p = $urandom_range(0, 31);
        t = p / 2;
        for (int k = 0; k < 16; k++) begin
            trig_in = (k >= t);
            @(negedge clk);
            check("trg_event", 32'(trg_event), 32'(k >= t));
        end
        check("event_pos", 32'(event_pos), 32'(2 * t));

        // Trace-mode readout
        reset_dut(TRACE, 2);
        @(negedge clk);
        w = $urandom();
        exp_q.push_back(w);
        load_grant = 1'b1;
        data_in    = w;
        @(negedge clk);
        load_grant = 1'b0;
        data_in    = $urandom();
        check("load_req_taken", 32'(load_req), 32'd0);
        repeat (6) @(negedge clk);
        check("load_req_before_bnd", 32'(load_req), 32'd0);
        @(negedge clk);
        check("load_req_after_bnd", 32'(load_req), 32'd1);
        got = '0;
        hi  = '0;
        for (int b = 0; b < 8; b++) begin
            got[b*4 +: 4] = stream[3:0];
            hi            = hi | {4'd0, stream[7:4]};
            @(negedge clk);
        end
        check("trace_stream_word", got, exp_q.pop_front());
        check("trace_stream_hi", 32'(hi), 32'd0);
        check("trig_o_delay_pre", 32'(trig_out), 32'd0);
        trg_delayed = 1'b1;
        @(negedge clk);
        check("trig_o_delay", 32'(trig_out), 32'd1);

        // Stream-mode readout
        reset_dut(STREAM, 1);
        @(negedge clk);
        check("stream_trig_idle", 32'(trig_out), 32'd0);
        w = $urandom();
        exp_q.push_back(w);
        load_grant = 1'b1;
        data_in    = w;
        @(negedge clk);
        load_grant = 1'b0;
        data_in    = $urandom();
        check("stream_valid", 32'(trig_out), 32'd1);
        check("stream_load_req", 32'(load_req), 32'd1);
        got   = '0;
        hi    = '0;
        reads = 0;
        iter  = 0;
        while (reads < 16 && iter < 400) begin
            r = 1'($urandom_range(0, 1));
            if (r) begin
                got[reads*2 +: 2] = stream[1:0];
                hi                = hi | {2'd0, stream[7:2]};
                reads++;
            end
            read_i = r;
            @(negedge clk);
            iter++;
        end
        read_i = 1'b0;
        if (reads < 16) check("stream_timeout", 32'(reads), 32'd16);
        check("stream_done", 32'(trig_out), 32'd0);
        check("stream_word", got, exp_q.pop_front());
        check("stream_hi", 32'(hi), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
